op_sweep_ctrl: RTL
==================

# op_sweep_ctrl

Sequencer that sits in front of the 8-operation logic unit and its 8:1 select mux. It drives the operand inputs and select lines and steps through all eight select codes, then assembles the mux outputs into one result vector. On a single `start` pulse it produces the complete operation signature of the latched operand pair and flags the result with `done`. It replaces hand-stepped select stimulus with a synthesizable controller.

## Interface
Parameters:
- `WIDTH`, 1, operand and mux-output width in bits.
- `SETTLE`, 1, number of cycles (≥1) each select code is held before its sample cycle.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a sweep. Accepted only in IDLE.
- `abort`  in  1  synchronous abort. Returns the block to IDLE without `done`.
- `in1`, `in2`  in  WIDTH  operands. Sampled when `start` is accepted.
- `mux_out`  in  WIDTH  output of the downstream 8:1 mux.
- `cin1`, `cin2`  out  WIDTH  registered operands driven to the op unit.
- `sel`  out  3  select code to the mux: `sel[2]`=s2, `sel[1]`=s1, `sel[0]`=s0.
- `busy`  out  1  high in SETTLE and SAMPLE.
- `done`  out  1  one-cycle pulse when `result` is complete.
- `result`  out  8*WIDTH  slot k = `result[k*WIDTH +: WIDTH]` holds the output for `sel`=k.
- `err`  out  1  self-check mismatch, sticky until the next accepted start (see Configuration).

## Operation
- Op codes:
  - 0 AND
  - 1 XOR
  - 2 NAND
  - 3 OR
  - 4 NOT in1
  - 5 NOT in2
  - 6 NOR
  - 7 XNOR
- FSM states:
  - IDLE → SETTLE on `start`. On this transition: latch `in1`/`in2` into `cin1`/`cin2`, set `sel`=0, clear `result` and `err`, load settle counter.
  - SETTLE: the counter decrements each cycle. After SETTLE cycles → SAMPLE.
  - SAMPLE: capture `mux_out` into slot `sel`. If `sel`=7 → DONE, else `sel`+1, reload counter, → SETTLE.
  - DONE: `done`=1 for this cycle only, then → IDLE.
- `sel` increments only on SAMPLE exit. There is no wrap during a sweep. `sel` stays 7 in DONE and IDLE until the next start.
- `result`, `cin1`, `cin2` hold their values in IDLE until the next accepted start.
- `start` while not in IDLE is ignored (no queueing).
- `abort` in any non-IDLE state → IDLE next cycle. In that case `done` is not pulsed, partial `result` is retained, and `sel` is held.
- `abort` and `start` high together in IDLE: `abort` wins and `start` is ignored.
- `in1`/`in2` changes during a sweep have no effect.

## Timing
- Reset (`rst_n`=0, asynchronous, any state including mid-sweep):
  - state IDLE
  - `sel`=0
  - `cin1`=`cin2`=0
  - `result`=0
  - `busy`=0, `done`=0, `err`=0
- Start accepted at edge E0. `busy`=1 from after E0 until the edge that enters DONE.
- Per op: SETTLE+1 cycles. `mux_out` is sampled at the end of the SAMPLE cycle, which is SETTLE+1 cycles after `sel` changed. `mux_out` must be combinationally valid within that window.
- `done` is high in the cycle after edge E0+8·(SETTLE+1). With SETTLE=1 that is 16 cycles after start.
- Earliest next start is in the cycle `done` is high: the start is sampled at the edge that leaves DONE and is ignored. The first accepted start is the following IDLE cycle.

## Configuration
- `OP_SWEEP_CHECK_EN` defined:
  - The block computes the expected value for op `sel` from `cin1`/`cin2` per the op table.
  - It compares that value to `mux_out` in each SAMPLE cycle.
  - On mismatch, `err` goes high the next cycle and stays high until the next accepted start or reset.
- Not defined: `err` tied to 0 and no checker logic is synthesized.

## Test plan
- WIDTH=1, SETTLE=1, `in1`=1, `in2`=0, start pulse, real op unit and mux attached → `sel` walks 0..7, 2 cycles per code; `done` 16 cycles after start; `result`=8'h2E; `err`=0.
- Same setup, `in1`=`in2`=1 → `result`=8'h89. With `in1`=`in2`=0 → `result`=8'hF4. Back-to-back sweeps: `result` cleared at each start.
- SETTLE=3, `in1`=1, `in2`=0 → each `sel` held 4 cycles; `done` 32 cycles after start; `result`=8'h2E.
- `abort` at cycle 7 after start → IDLE next cycle, no `done`, `busy`=0, `sel` held; a new `start` gives a full 16-cycle sweep. `start` pulses mid-sweep are ignored.
- `rst_n` low asynchronously mid-sweep (between edges) → all outputs zero immediately; after release, block idle until `start`.
- With `OP_SWEEP_CHECK_EN`, `mux_out` forced to 0 during `sel`=1 (`in1`=1, `in2`=0) → `err`=1 from the cycle after that SAMPLE, held through `done`, cleared at the next start.

Source files
------------

// File: rtl/op_sweep_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | op_sweep_ctrl: steps an 8:1 op-mux through all select codes and gathers   |
// | its outputs into one signature. Optional self-check: OP_SWEEP_CHECK_EN.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module op_sweep_ctrl #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  input  logic [WIDTH-1:0]     mux_out,
  output logic [WIDTH-1:0]     cin1,
  output logic [WIDTH-1:0]     cin2,
  output logic [2:0]           sel,
  output logic                 busy,
  output logic                 done,
  output logic [8*WIDTH-1:0]   result,
  output logic                 err
);

  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_settle = 2'd1;
  localparam logic [1:0] c_st_sample = 2'd2;
  localparam logic [1:0] c_st_done   = 2'd3;

  localparam logic [CW-1:0] c_settle_cnt = CW'(SETTLE);
  localparam logic [CW-1:0] c_cnt_one    = CW'(1);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [2:0]         r_sel;
  logic [WIDTH-1:0]   r_cin1;
  logic [WIDTH-1:0]   r_cin2;
  logic [8*WIDTH-1:0] r_result;
  logic               w_accept;

  assign w_accept = (r_state == c_st_idle) && start && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_st_idle;
      r_cnt    <= '0;
      r_sel    <= 3'd0;
      r_cin1   <= '0;
      r_cin2   <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_state  <= c_st_settle;
            r_cin1   <= in1;
            r_cin2   <= in2;
            r_sel    <= 3'd0;
            r_result <= '0;
            r_cnt    <= c_settle_cnt;
          end
        end
        c_st_settle: begin
          if (abort) begin
            r_state <= c_st_idle;
          end else if (r_cnt == c_cnt_one) begin
            r_state <= c_st_sample;
          end else begin
            r_cnt <= r_cnt - c_cnt_one;
          end
        end
        c_st_sample: begin
          // Abort wins over the capture so a partial result never gains a slot late.
          if (abort) begin
            r_state <= c_st_idle;
          end else begin
            for (int k = 0; k < 8; k++) begin
              if (r_sel == 3'(k)) r_result[k*WIDTH +: WIDTH] <= mux_out;
            end
            if (r_sel == 3'd7) begin
              r_state <= c_st_done;
            end else begin
              r_sel   <= r_sel + 3'd1;
              r_cnt   <= c_settle_cnt;
              r_state <= c_st_settle;
            end
          end
        end
        c_st_done: begin
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign cin1   = r_cin1;
  assign cin2   = r_cin2;
  assign sel    = r_sel;
  assign result = r_result;
  assign busy   = (r_state == c_st_settle) || (r_state == c_st_sample);
  assign done   = (r_state == c_st_done);

`ifdef OP_SWEEP_CHECK_EN
  logic [WIDTH-1:0] w_expect;
  logic             r_err;

  always_comb begin
    w_expect = '0;
    case (r_sel)
      3'd0:    w_expect = r_cin1 & r_cin2;
      3'd1:    w_expect = r_cin1 ^ r_cin2;
      3'd2:    w_expect = ~(r_cin1 & r_cin2);
      3'd3:    w_expect = r_cin1 | r_cin2;
      3'd4:    w_expect = ~r_cin1;
      3'd5:    w_expect = ~r_cin2;
      3'd6:    w_expect = ~(r_cin1 | r_cin2);
      default: w_expect = ~(r_cin1 ^ r_cin2);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if ((r_state == c_st_sample) && !abort && (mux_out != w_expect)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire
